// File: rtl/serial_byte_rx_pkg.sv
// Shared types and constants for the serial byte receiver:
// FSM state encoding, default frame width and the hex-to-segment table.
package serial_rx_pkg;

    localparam int NBITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        RESYNC = 3'd4
    } rx_state_t;

    // Segment images indexed by nibble value; bit0=a .. bit6=g, active-high.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/serial_byte_rx_if.sv
// Receiver-side bundle: the incoming serial line plus everything the
// receiver reports back. The slave side is the receiver itself.
interface serial_byte_rx_if #(
    parameter int NBITS = serial_rx_pkg::NBITS_DEF
);
    logic             serial_in;
    logic [NBITS-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             parity_err;
    logic             busy;
    logic [7:0]       byte_count;
    logic [7:0]       SEG;

    modport master (
        output serial_in,
        input  data_out, data_valid, frame_err, parity_err, busy, byte_count, SEG
    );

    modport slave (
        input  serial_in,
        output data_out, data_valid, frame_err, parity_err, busy, byte_count, SEG
    );
endinterface

// File: rtl/serial_byte_rx_hex7seg.sv
// Nibble to seven-segment decode (a..g, active-high), no decimal point.
module hex7seg
    import serial_rx_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[hex];
endmodule

// File: rtl/serial_byte_rx.sv
// Serial byte receiver: start bit (0), NBITS data bits LSB first,
// optional even-parity bit, stop bit (1). One bit per clk_2 cycle.
// Optional feature macro: SERIAL_BYTE_RX_PARITY_EN enables the parity bit.
module serial_byte_rx
    import serial_rx_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk_2,
    input  logic             reset,
    serial_byte_rx_if.slave  rx
);
    localparam int             CW   = $clog2(NBITS + 1);
    localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

    rx_state_t        state;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [NBITS-1:0] data_out_r;
    logic             data_valid_r;
    logic             frame_err_r;
    logic [7:0]       byte_count_r;
    logic             parity_err_r;
    // Parity failure of the frame in flight, separate from the sticky flag
    // so a stale error from an older frame cannot veto a clean frame.
    logic             par_bad;
    logic [6:0]       seg7;

`ifndef SERIAL_BYTE_RX_PARITY_EN
    assign parity_err_r = 1'b0;
    assign par_bad      = 1'b0;
`endif

    // Frame FSM with all datapath and status registers.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            byte_count_r <= 8'd0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
            parity_err_r <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            data_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx.serial_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    shreg   <= {rx.serial_in, shreg[NBITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST) begin
`ifdef SERIAL_BYTE_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef SERIAL_BYTE_RX_PARITY_EN
                    // Even parity: the parity bit must equal the XOR of the data.
                    if (rx.serial_in != ^shreg) begin
                        par_bad      <= 1'b1;
                        parity_err_r <= 1'b1;
                    end
                    state <= STOP;
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (rx.serial_in) begin
                        if (!par_bad) begin
                            data_out_r   <= shreg;
                            data_valid_r <= 1'b1;
                            byte_count_r <= byte_count_r + 8'd1;
                            frame_err_r  <= 1'b0;
`ifdef SERIAL_BYTE_RX_PARITY_EN
                            parity_err_r <= 1'b0;
`endif
                        end
                        state <= IDLE;
                    end else begin
                        frame_err_r <= 1'b1;
                        state       <= RESYNC;
                    end
                end
                RESYNC: begin
                    // Wait for the line to return high before hunting a start bit.
                    if (rx.serial_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hex7seg u_hex7seg (
        .hex (data_out_r[3:0]),
        .seg (seg7)
    );

    assign rx.data_out   = data_out_r;
    assign rx.data_valid = data_valid_r;
    assign rx.frame_err  = frame_err_r;
    assign rx.parity_err = parity_err_r;
    assign rx.busy       = (state != IDLE);
    assign rx.byte_count = byte_count_r;
    assign rx.SEG        = {frame_err_r | parity_err_r, seg7};

endmodule

// File: tb/tb_serial_byte_rx.sv
// Self-checking bench for serial_byte_rx with a scoreboard of expected frames.
// Build with SERIAL_BYTE_RX_PARITY_EN defined to exercise the parity bit.
module tb_serial_byte_rx;

    localparam int NBITS = 8;
`ifdef SERIAL_BYTE_RX_PARITY_EN
    localparam int LAT = NBITS + 3;
`else
    localparam int LAT = NBITS + 2;
`endif

    typedef struct {
        logic [7:0] data;
        int         due;
        logic [7:0] cnt;
        logic [7:0] seg;
    } exp_t;

    logic clk_2 = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] exp_cnt = 8'd0;
    exp_t sb[$];
    exp_t mon_e;

    serial_byte_rx_if #(.NBITS(NBITS)) rx_if ();

    serial_byte_rx #(.NBITS(NBITS)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .rx    (rx_if)
    );

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one bit for one clock period; returns 1 time unit after the sampling edge.
    task automatic drive_bit(input logic b);
        rx_if.serial_in = b;
        @(posedge clk_2);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        exp_t e;
        e.due = cyc + LAT;
        if (stop && !pflip) begin
            exp_cnt = exp_cnt + 8'd1;
            e.data  = d;
            e.cnt   = exp_cnt;
            e.seg   = {1'b0, seg_ref(d[3:0])};
            sb.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < NBITS; i++) drive_bit(d[i]);
`ifdef SERIAL_BYTE_RX_PARITY_EN
        drive_bit((^d) ^ pflip);
`endif
        drive_bit(stop);
    endtask

    // Output monitor: every data_valid pulse must match the oldest expected frame.
    always @(negedge clk_2) begin
        if (rx_if.data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("data_out", 32'(rx_if.data_out), 32'(mon_e.data));
                check("valid_cycle", 32'(cyc), 32'(mon_e.due));
                check("byte_count", 32'(rx_if.byte_count), 32'(mon_e.cnt));
                check("seg", 32'(rx_if.SEG), 32'(mon_e.seg));
                check("err_cleared", {30'd0, rx_if.frame_err, rx_if.parity_err}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.serial_in = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk_2);
        #1;
        check("rst_data_out", 32'(rx_if.data_out), 32'd0);
        check("rst_valid", 32'(rx_if.data_valid), 32'd0);
        check("rst_busy", 32'(rx_if.busy), 32'd0);
        check("rst_count", 32'(rx_if.byte_count), 32'd0);
        check("rst_seg", 32'(rx_if.SEG), 32'h3F);
        check("rst_errs", {30'd0, rx_if.frame_err, rx_if.parity_err}, 32'd0);
        reset = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Single 0xA5 frame.
        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("a5_data", 32'(rx_if.data_out), 32'hA5);
        check("a5_seg", 32'(rx_if.SEG), 32'h6D);
        check("a5_count", 32'(rx_if.byte_count), 32'd1);
        check("a5_busy", 32'(rx_if.busy), 32'd0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("b2b_count", 32'(rx_if.byte_count), 32'd3);

        // Framing error, RESYNC hold and release.
        send_frame(8'h5A, 1'b0, 1'b0);
        check("ferr_flag", 32'(rx_if.frame_err), 32'd1);
        check("ferr_dp", 32'(rx_if.SEG[7]), 32'd1);
        check("ferr_data_kept", 32'(rx_if.data_out), 32'hC3);
        check("ferr_count_kept", 32'(rx_if.byte_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b0);
            check("resync_busy", 32'(rx_if.busy), 32'd1);
        end
        drive_bit(1'b1);
        check("resync_exit", 32'(rx_if.busy), 32'd0);
        check("ferr_sticky", 32'(rx_if.frame_err), 32'd1);
        send_frame(8'h0F, 1'b1, 1'b0);
        drive_bit(1'b1);
        check("ferr_cleared", 32'(rx_if.frame_err), 32'd0);

`ifdef SERIAL_BYTE_RX_PARITY_EN
        // Bad parity with a good stop bit: flagged, not delivered.
        send_frame(8'hA5, 1'b1, 1'b1);
        drive_bit(1'b1);
        check("perr_flag", 32'(rx_if.parity_err), 32'd1);
        check("perr_dp", 32'(rx_if.SEG[7]), 32'd1);
        check("perr_count_kept", 32'(rx_if.byte_count), 32'(exp_cnt));
        check("perr_busy", 32'(rx_if.busy), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1);
        check("perr_cleared", 32'(rx_if.parity_err), 32'd0);
`else
        check("parity_tied", 32'(rx_if.parity_err), 32'd0);
`endif

        // 256 frames: the counter must come back to the same value.
        for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("wrap_count", 32'(rx_if.byte_count), 32'(exp_cnt));

        // Reset in cycle 4 of a frame, then a clean frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset = 1'b0;
        #1;
        check("midrst_data_out", 32'(rx_if.data_out), 32'd0);
        check("midrst_valid", 32'(rx_if.data_valid), 32'd0);
        check("midrst_busy", 32'(rx_if.busy), 32'd0);
        check("midrst_count", 32'(rx_if.byte_count), 32'd0);
        check("midrst_seg", 32'(rx_if.SEG), 32'h3F);
        check("midrst_errs", {30'd0, rx_if.frame_err, rx_if.parity_err}, 32'd0);
        exp_cnt = 8'd0;
        sb.delete();
        #2;
        reset = 1'b1;
        rx_if.serial_in = 1'b1;
        @(posedge clk_2);
        #1;
        drive_bit(1'b1);
        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("post_rst_data", 32'(rx_if.data_out), 32'hA5);
        check("post_rst_count", 32'(rx_if.byte_count), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_byte_rx.md
SERIAL_BYTE_RX -- requirements
Module: serial_byte_rx

Interface
REQ-001 Parameter: NBITS, default 8, data bits per frame and width of data_out.
REQ-002 Port: clk_2, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, reset is asynchronous and active-low; 0 clears all state.
REQ-004 Port: serial_in, input, 1, serial bit stream, one bit per clk_2 cycle, idle level 1.
REQ-005 Port: data_out, output, NBITS, last correctly framed byte.
REQ-006 Port: data_valid, output, 1, one-cycle pulse when data_out updates.
REQ-007 Port: frame_err, output, 1, stop bit was 0 on the last frame (sticky).
REQ-008 Port: parity_err, output, 1, parity mismatch on the last frame (sticky).
REQ-009 Port: busy, output, 1, high whenever the state is not IDLE.
REQ-010 Port: byte_count, output, 8, count of accepted frames.
REQ-011 Port: SEG, output, 8, seven-segment image of data_out[3:0]; bit0=a..bit6=g active-high, bit7=dp=frame_err|parity_err.

Function
REQ-012 FSM states: IDLE, DATA, PARITY, STOP, RESYNC.
REQ-013 IDLE: serial_in=0 samples the start bit; next state DATA, bit counter cleared; serial_in=1 stays IDLE.
REQ-014 DATA: each cycle shift right, LSB first (shreg <= {serial_in, shreg[NBITS-1:1]}); after NBITS bits go to PARITY if enabled, else STOP.
REQ-015 STOP with serial_in=1 and no parity error: data_out<=shreg, data_valid=1 next cycle, byte_count+1, both error flags cleared, go IDLE.
REQ-016 STOP with serial_in=0: frame_err=1, no data_valid, data_out and byte_count unchanged, go RESYNC.
REQ-017 RESYNC: stay while serial_in=0; go IDLE on serial_in=1.
REQ-018 Latency: start bit sampled at cycle 0, data at cycles 1..NBITS, stop at NBITS+1 (no parity); data_valid high in cycle NBITS+2.
REQ-019 Back-to-back frames: a start bit in the cycle right after STOP is accepted with no idle gap.
REQ-020 byte_count wraps 255 -> 0 with no flag.
REQ-021 Error flags stay set until the next accepted frame or reset.
REQ-022 SEG is purely combinational from registered data_out and the error flags.

Reset
REQ-023 On reset=0, immediately: state IDLE; shreg, counters, data_out, byte_count and all flags 0; SEG=8'h3F.
REQ-024 Reset mid-frame discards the partial byte; the first frame after release starts fresh.

Configuration
REQ-025 Macro SERIAL_BYTE_RX_PARITY_EN: when defined, the PARITY state samples one even-parity bit after the data bits, and stop is sampled one cycle later; on a mismatch, parity_err=1, no data_valid, and the FSM still checks the stop bit.
REQ-026 Without SERIAL_BYTE_RX_PARITY_EN: the PARITY state is never entered and parity_err is tied to 0.

Structure
REQ-027 Package serial_rx_pkg holds the state enum typedef, the NBITS default, and the 16-entry hex-to-segment constant table.
REQ-028 Sub-module hex7seg (4-bit in, 7-bit out) performs the segment decode; the dp bit is added in serial_byte_rx.

Verification
REQ-029 Assert reset=0 at cycle 4 of a frame -> all outputs 0, SEG=8'h3F, busy=0; a following 0xA5 frame is received correctly.
REQ-030 Drive 1,0,1,0,1,0,0,1,0,1,1 (0xA5) -> data_out=8'hA5, single data_valid pulse 10 cycles after start sample, byte_count=1, SEG=8'h6D.
REQ-031 Drive a frame with stop bit=0 -> frame_err=1, SEG[7]=1, no data_valid, RESYNC held while serial_in=0, IDLE after serial_in=1.
REQ-032 Send 0x3C then 0xC3 back-to-back -> two data_valid pulses exactly 10 cycles apart, byte_count=2.
REQ-033 Send 256 valid frames -> byte_count returns to 0.
REQ-034 With SERIAL_BYTE_RX_PARITY_EN, send 0xA5 with parity 0 -> accepted; send 0xA5 with parity 1 -> parity_err=1, no data_valid.
